// File: rtl/vcache_dma_responder_pkg.sv
// vcache_dma_responder_pkg: FSM state encoding shared by the DMA responder and its bench
package vcache_dma_responder_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SEND, RECV} vcache_dma_responder_state_e;
  localparam int lat_width_lp = 8;
endpackage

// File: rtl/vcache_dma_responder_mem.sv
// vcache_dma_responder_mem: 1r1w word array with async read (clk_i, w_v_i/w_addr_i/w_data_i write port, r_addr_i/r_data_o read port)
module vcache_dma_responder_mem #(
  parameter int width_p = 32,
  parameter int els_p = 64,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);
  logic [width_p-1:0] mem [els_p];
  always_ff @(posedge clk_i)
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  assign r_data_o = mem[r_addr_i];
endmodule

// File: rtl/vcache_dma_responder.sv
// vcache_dma_responder: vcache DMA memory model (clk_i/reset_i; dma_pkt_* packet in; dma_data_o/v_o/ready_i fill out; dma_data_i/v_i/yumi_o eviction in; read/write request counters)
module vcache_dma_responder
  import vcache_dma_responder_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int block_size_in_words_p = 8,
  parameter int mem_els_p = 1024,
  parameter int latency_p = 0,
  localparam int dma_pkt_width_lp = addr_width_p + 1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic                        dma_pkt_v_i,
  output logic                        dma_pkt_yumi_o,
  output logic [data_width_p-1:0]     dma_data_o,
  output logic                        dma_data_v_o,
  input  logic                        dma_data_ready_i,
  input  logic [data_width_p-1:0]     dma_data_i,
  input  logic                        dma_data_v_i,
  output logic                        dma_data_yumi_o,
  output logic [31:0]                 read_req_count_o,
  output logic [31:0]                 write_req_count_o
);
  localparam int byte_off_lp = $clog2(data_width_p / 8);
  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam int blk_w_lp = $clog2(block_size_in_words_p);
  if (!(data_width_p == 32 || data_width_p == 64)) begin : g_bad_dw
    $error("data_width_p must be 32 or 64");
  end
  if (block_size_in_words_p < 2 || (block_size_in_words_p & (block_size_in_words_p - 1)) != 0) begin : g_bad_bs
    $error("block_size_in_words_p must be a power of two >= 2");
  end
  if ((mem_els_p & (mem_els_p - 1)) != 0 || mem_els_p <= block_size_in_words_p) begin : g_bad_els
    $error("mem_els_p must be a power of two larger than the block");
  end
  if (latency_p < 0 || latency_p > 255) begin : g_bad_lat
    $error("latency_p must be in 0..255");
  end
  if (addr_width_p < byte_off_lp + idx_w_lp) begin : g_bad_aw
    $error("addr_width_p too narrow for mem_els_p");
  end
  vcache_dma_responder_state_e state;
  logic [idx_w_lp-blk_w_lp-1:0] blk;
  logic [blk_w_lp-1:0] ctr;
  logic [lat_width_lp-1:0] lat;
  logic [31:0] rd_cnt, wr_cnt;
  logic [addr_width_p-1:0] word_idx;
  logic pkt_wnr, unused;
  assign pkt_wnr = dma_pkt_i[addr_width_p];
  assign word_idx = dma_pkt_i[addr_width_p-1:0] >> byte_off_lp;
  assign unused = ^dma_pkt_i;
  assign dma_pkt_yumi_o = dma_pkt_v_i & (state == IDLE) & ~reset_i;
  assign dma_data_v_o = state == SEND;
  assign dma_data_yumi_o = dma_data_v_i & (state == RECV);
  assign read_req_count_o = rd_cnt;
  assign write_req_count_o = wr_cnt;
  // lat is preloaded with latency_p-1 so the first fill word appears latency_p cycles after yumi
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state <= IDLE;
      blk <= '0;
      ctr <= '0;
      lat <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else
      case (state)
        IDLE: if (dma_pkt_v_i) begin
          blk <= word_idx[idx_w_lp-1:blk_w_lp];
          if (pkt_wnr) begin
            state <= RECV;
            wr_cnt <= wr_cnt + 32'd1;
          end else begin
            state <= latency_p <= 1 ? SEND : WAIT;
            lat <= lat_width_lp'(latency_p > 1 ? latency_p - 1 : 0);
            rd_cnt <= rd_cnt + 32'd1;
          end
        end
        WAIT: begin
          lat <= lat - 1'b1;
          if (lat == 1) state <= SEND;
        end
        SEND: if (dma_data_ready_i) begin
          ctr <= ctr + 1'b1;
          if (&ctr) state <= IDLE;
        end
        RECV: if (dma_data_v_i) begin
          ctr <= ctr + 1'b1;
          if (&ctr) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  vcache_dma_responder_mem #(.width_p(data_width_p), .els_p(mem_els_p)) mem (
    .clk_i(clk_i),
    .w_v_i(dma_data_yumi_o & ~reset_i),
    .w_addr_i({blk, ctr}),
    .w_data_i(dma_data_i),
    .r_addr_i({blk, ctr}),
    .r_data_o(dma_data_o)
  );
  a_no_wdata_in_send: assert property (@(posedge clk_i) disable iff (reset_i) !(state == SEND && dma_data_v_i));
endmodule

// File: tb/tb_vcache_dma_responder.sv
// tb_vcache_dma_responder: table-driven and scoreboard checks of the DMA responder
module tb_vcache_dma_responder;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] dbase;
    int          stall_at;
    int          stall_len;
    int          exp_rd;
    int          exp_wr;
  } vec_t;
  logic clk = 0;
  logic rst [2];
  logic [32:0] pkt [2];
  logic pkt_v [2], pkt_yumi [2];
  logic [31:0] dout [2], din [2], rd_cnt [2], wr_cnt [2];
  logic dv [2], ready [2], dv_i [2], d_yumi [2];
  logic [31:0] sb [$];
  int checks = 0, errors = 0;
  vec_t vecs [5];
  always #5 clk = ~clk;
  vcache_dma_responder #(.data_width_p(32), .addr_width_p(32), .block_size_in_words_p(8),
    .mem_els_p(64), .latency_p(4)) u0 (
    .clk_i(clk), .reset_i(rst[0]), .dma_pkt_i(pkt[0]), .dma_pkt_v_i(pkt_v[0]),
    .dma_pkt_yumi_o(pkt_yumi[0]), .dma_data_o(dout[0]), .dma_data_v_o(dv[0]),
    .dma_data_ready_i(ready[0]), .dma_data_i(din[0]), .dma_data_v_i(dv_i[0]),
    .dma_data_yumi_o(d_yumi[0]), .read_req_count_o(rd_cnt[0]), .write_req_count_o(wr_cnt[0]));
  vcache_dma_responder #(.data_width_p(32), .addr_width_p(32), .block_size_in_words_p(8),
    .mem_els_p(64), .latency_p(0)) u1 (
    .clk_i(clk), .reset_i(rst[1]), .dma_pkt_i(pkt[1]), .dma_pkt_v_i(pkt_v[1]),
    .dma_pkt_yumi_o(pkt_yumi[1]), .dma_data_o(dout[1]), .dma_data_v_o(dv[1]),
    .dma_data_ready_i(ready[1]), .dma_data_i(din[1]), .dma_data_v_i(dv_i[1]),
    .dma_data_yumi_o(d_yumi[1]), .read_req_count_o(rd_cnt[1]), .write_req_count_o(wr_cnt[1]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic wait_pkt(input int u, input bit wr, input logic [31:0] addr);
    int n = 0;
    pkt[u] = {wr, addr};
    pkt_v[u] = 1;
    #1;
    while (!pkt_yumi[u] && n < 50) begin
      tick;
      n++;
    end
    chk("pkt yumi", {31'd0, pkt_yumi[u]}, 1);
  endtask
  task automatic do_write(input int u, input logic [31:0] addr, input logic [31:0] dbase);
    wait_pkt(u, 1, addr);
    tick;
    pkt_v[u] = 0;
    for (int i = 0; i < 8; i++) begin
      dv_i[u] = 1;
      din[u] = dbase + i;
      #1;
      chk("wr data yumi", {31'd0, d_yumi[u]}, 1);
      tick;
    end
    dv_i[u] = 0;
  endtask
  task automatic do_read(input int u, input logic [31:0] addr, input int exp_lat,
                         input int stall_at, input int stall_len);
    int cyc = 1, acc = 0, hold = 0, guard = 0;
    wait_pkt(u, 0, addr);
    tick;
    pkt_v[u] = 0;
    while (!dv[u] && cyc < 300) begin
      tick;
      cyc++;
    end
    chk("read latency", cyc, exp_lat);
    while (acc < 8 && guard < 100) begin
      ready[u] = !(acc == stall_at && hold < stall_len);
      #1;
      if (!dv[u]) chk("valid during send", {31'd0, dv[u]}, 1);
      else if (ready[u]) begin
        chk("fill word", dout[u], sb.pop_front());
        acc++;
      end else begin
        chk("held word", dout[u], sb[0]);
        hold++;
      end
      tick;
      guard++;
    end
    ready[u] = 0;
    chk("accept count", acc, 8);
    chk("idle after fill", {31'd0, dv[u]}, 0);
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1; pkt[u] = '0; pkt_v[u] = 0; ready[u] = 0; din[u] = '0; dv_i[u] = 0;
    end
    vecs[0] = '{1, 32'h100, 32'hA0, -1, 0, 0, 1};
    vecs[1] = '{0, 32'h100, 32'hA0, -1, 0, 1, 1};
    vecs[2] = '{0, 32'h10C, 32'hA0, 2, 3, 2, 1};
    vecs[3] = '{1, 32'h120, 32'hB0, -1, 0, 2, 2};
    vecs[4] = '{0, 32'h020, 32'hB0, -1, 0, 3, 2};
    tick;
    tick;
    rst[0] = 0;
    rst[1] = 0;
    dv_i[0] = 1;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("reset rd count", rd_cnt[u], 0);
      chk("reset wr count", wr_cnt[u], 0);
      chk("reset data valid", {31'd0, dv[u]}, 0);
    end
    chk("data yumi in idle", {31'd0, d_yumi[0]}, 0);
    dv_i[0] = 0;
    foreach (vecs[k]) begin
      if (vecs[k].wr) do_write(0, vecs[k].addr, vecs[k].dbase);
      else begin
        for (int i = 0; i < 8; i++) sb.push_back(vecs[k].dbase + i);
        do_read(0, vecs[k].addr, 4, vecs[k].stall_at, vecs[k].stall_len);
      end
      chk("rd count", rd_cnt[0], vecs[k].exp_rd);
      chk("wr count", wr_cnt[0], vecs[k].exp_wr);
    end
    do_write(0, 32'h180, 32'hC0);
    wait_pkt(0, 1, 32'h180);
    tick;
    pkt_v[0] = 0;
    for (int i = 0; i < 3; i++) begin
      dv_i[0] = 1;
      din[0] = 32'hD0 + i;
      tick;
    end
    din[0] = 32'hD3;
    rst[0] = 1;
    tick;
    rst[0] = 0;
    din[0] = 32'hDEAD;
    #1;
    chk("post-reset data yumi", {31'd0, d_yumi[0]}, 0);
    chk("post-reset pkt yumi", {31'd0, pkt_yumi[0]}, 0);
    chk("post-reset rd count", rd_cnt[0], 0);
    chk("post-reset wr count", wr_cnt[0], 0);
    chk("post-reset valid", {31'd0, dv[0]}, 0);
    tick;
    dv_i[0] = 0;
    for (int i = 0; i < 3; i++) sb.push_back(32'hD0 + i);
    for (int i = 3; i < 8; i++) sb.push_back(32'hC0 + i);
    do_read(0, 32'h180, 4, -1, 0);
    chk("rd count after reset", rd_cnt[0], 1);
    do_write(1, 32'h40, 32'hE0);
    for (int i = 0; i < 16; i++) sb.push_back(32'hE0 + (i % 8));
    wait_pkt(1, 0, 32'h40);
    tick;
    chk("lat0 valid", {31'd0, dv[1]}, 1);
    ready[1] = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("second pkt held", {31'd0, pkt_yumi[1]}, 0);
      chk("lat0 fill word", dout[1], sb.pop_front());
      tick;
    end
    #1;
    chk("second pkt accepted", {31'd0, pkt_yumi[1]}, 1);
    tick;
    pkt_v[1] = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("second fill valid", {31'd0, dv[1]}, 1);
      chk("second fill word", dout[1], sb.pop_front());
      tick;
    end
    ready[1] = 0;
    chk("u1 rd count", rd_cnt[1], 2);
    chk("u1 wr count", wr_cnt[1], 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
